// File: rtl/bsg_handshake_monitor.sv
// bsg_handshake_monitor: passive valid/ready checker counting transfers and flagging drop, unstable-payload and stall-timeout errors
module bsg_handshake_monitor #(
  parameter int channels_p    = 4,
  parameter int width_p       = 64,
  parameter int count_width_p = 32,
  parameter int timeout_p     = 1024,
  localparam int chan_w_lp    = channels_p > 1 ? $clog2(channels_p) : 1,
  localparam int stall_w_lp   = $clog2(timeout_p + 1)
) (
  input  logic                                  clk_i,
  input  logic                                  reset_i,
  input  logic                                  en_i,
  input  logic                                  clear_i,
  input  logic [channels_p-1:0]                 valid_i,
  input  logic [channels_p-1:0]                 ready_i,
  input  logic [channels_p*width_p-1:0]         data_i,
  output logic [channels_p*count_width_p-1:0]   count_o,
  output logic [channels_p*3-1:0]               err_sticky_o,
  output logic                                  err_v_o,
  output logic                                  first_err_v_o,
  output logic [chan_w_lp-1:0]                  first_err_chan_o,
  output logic [1:0]                            first_err_code_o
);
  logic [channels_p-1:0] stall, stall_q, stall_d;
  logic [channels_p-1:0][width_p-1:0] data_q, data_d;
  logic [channels_p-1:0][stall_w_lp-1:0] scnt_q, scnt_d;
  logic [channels_p-1:0][count_width_p-1:0] count_q, count_d;
  logic [channels_p*3-1:0] det, sticky_q, sticky_d;
  logic err_v_q, err_v_d, first_v_q, first_v_d;
  logic [chan_w_lp-1:0] first_chan_q, first_chan_d, sel_chan;
  logic [1:0] first_code_q, first_code_d, sel_code;
  assign stall = valid_i & ~ready_i;
  always_comb begin
    det = '0;
    sel_chan = '0;
    sel_code = '0;
    for (int i = 0; i < channels_p; i++) begin
      det[3*i]   = en_i & stall_q[i] & ~valid_i[i];
      det[3*i+1] = en_i & stall_q[i] & valid_i[i] & (data_i[i*width_p +: width_p] != data_q[i]);
      det[3*i+2] = en_i & stall[i] & (scnt_q[i] == stall_w_lp'(timeout_p - 1));
      stall_d[i] = ~clear_i & en_i & stall[i];
      data_d[i]  = clear_i ? '0 : en_i ? data_i[i*width_p +: width_p] : data_q[i];
      scnt_d[i]  = !stall_d[i] ? '0
                 : scnt_q[i] == stall_w_lp'(timeout_p) ? scnt_q[i] : scnt_q[i] + 1'b1;
      count_d[i] = clear_i ? '0
                 : (en_i && valid_i[i] && ready_i[i] && count_q[i] != '1) ? count_q[i] + 1'b1 : count_q[i];
    end
    // Scan downward so the lowest detecting channel ends up selected
    for (int i = channels_p - 1; i >= 0; i--)
      if (|det[3*i +: 3]) begin
        sel_chan = chan_w_lp'(i);
        sel_code = det[3*i] ? 2'b01 : det[3*i+1] ? 2'b10 : 2'b11;
      end
    sticky_d     = clear_i ? '0 : sticky_q | det;
    err_v_d      = ~clear_i & (|det);
    first_v_d    = ~clear_i & (first_v_q | (|det));
    first_chan_d = clear_i ? '0 : (!first_v_q && |det) ? sel_chan : first_chan_q;
    first_code_d = clear_i ? '0 : (!first_v_q && |det) ? sel_code : first_code_q;
  end
  always_ff @(posedge clk_i or posedge reset_i)
    if (reset_i) begin
      stall_q      <= '0;
      data_q       <= '0;
      scnt_q       <= '0;
      count_q      <= '0;
      sticky_q     <= '0;
      err_v_q      <= 1'b0;
      first_v_q    <= 1'b0;
      first_chan_q <= '0;
      first_code_q <= '0;
    end else begin
      stall_q      <= stall_d;
      data_q       <= data_d;
      scnt_q       <= scnt_d;
      count_q      <= count_d;
      sticky_q     <= sticky_d;
      err_v_q      <= err_v_d;
      first_v_q    <= first_v_d;
      first_chan_q <= first_chan_d;
      first_code_q <= first_code_d;
    end
  assign count_o          = count_q;
  assign err_sticky_o     = sticky_q;
  assign err_v_o          = err_v_q;
  assign first_err_v_o    = first_v_q;
  assign first_err_chan_o = first_chan_q;
  assign first_err_code_o = first_code_q;
endmodule

// File: tb/tb_bsg_handshake_monitor.sv
// tb_bsg_handshake_monitor: directed bench for counting, drop/unstable/timeout detection, first-error capture, clear and reset
module tb_bsg_handshake_monitor;
  localparam int C = 4, W = 8, N = 3, T = 4;
  logic clk_i = 1'b0;
  logic reset_i, en_i, clear_i;
  logic [C-1:0] valid_i, ready_i;
  logic [C*W-1:0] data_i;
  logic [C*N-1:0] count_o;
  logic [C*3-1:0] err_sticky_o;
  logic err_v_o, first_err_v_o;
  logic [1:0] first_err_chan_o, first_err_code_o;
  int checks = 0, errors = 0, pulses;
  bsg_handshake_monitor #(.channels_p(C), .width_p(W), .count_width_p(N), .timeout_p(T)) u_dut (
    .clk_i(clk_i), .reset_i(reset_i), .en_i(en_i), .clear_i(clear_i),
    .valid_i(valid_i), .ready_i(ready_i), .data_i(data_i),
    .count_o(count_o), .err_sticky_o(err_sticky_o), .err_v_o(err_v_o),
    .first_err_v_o(first_err_v_o), .first_err_chan_o(first_err_chan_o),
    .first_err_code_o(first_err_code_o)
  );
  always #5 clk_i = ~clk_i;
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask
  task automatic step();
    @(posedge clk_i);
    #1;
  endtask
  task automatic idle();
    valid_i = '0;
    ready_i = '0;
  endtask
  task automatic clr();
    idle();
    clear_i = 1'b1;
    step();
    clear_i = 1'b0;
  endtask
  task automatic chk_zero(input string tag);
    chk({tag, "_cnt"}, 64'(count_o), 0);
    chk({tag, "_sticky"}, 64'(err_sticky_o), 0);
    chk({tag, "_first"}, {first_err_v_o, first_err_chan_o, first_err_code_o}, 0);
  endtask
  initial begin
    reset_i = 1'b1; en_i = 1'b0; clear_i = 1'b0; data_i = '0;
    idle();
    step(); step();
    chk_zero("rst");
    chk("rst_errv", 64'(err_v_o), 0);
    reset_i = 1'b0;
    en_i = 1'b1;
    valid_i[0] = 1'b1; ready_i[0] = 1'b1;
    repeat (5) step();
    chk("cnt5", 64'(count_o[N-1:0]), 5);
    chk("cnt5_sticky", 64'(err_sticky_o), 0);
    repeat (4) step();
    chk("cnt_sat", 64'(count_o[N-1:0]), 7);
    en_i = 1'b0;
    step();
    chk("en0_hold", 64'(count_o[N-1:0]), 7);
    en_i = 1'b1;
    idle();
    step();
    valid_i[2] = 1'b1;
    step();
    valid_i[2] = 1'b0;
    step();
    chk("drop_sticky", 64'(err_sticky_o), 64'h40);
    chk("drop_errv", 64'(err_v_o), 1);
    chk("drop_first", {first_err_v_o, first_err_chan_o, first_err_code_o}, 5'b1_10_01);
    step();
    chk("drop_errv_pulse", 64'(err_v_o), 0);
    clr();
    chk_zero("clr1");
    valid_i[0] = 1'b1;
    step();
    en_i = 1'b0; valid_i[0] = 1'b0;
    step();
    en_i = 1'b1;
    step();
    chk("en0_nodet", {err_v_o, 64'(err_sticky_o)}, 0);
    valid_i[1] = 1'b1; data_i[W +: W] = 8'hA;
    step();
    data_i[W +: W] = 8'hB;
    step();
    chk("unst_sticky", 64'(err_sticky_o), 64'h10);
    chk("unst_first", {first_err_v_o, first_err_chan_o, first_err_code_o}, 5'b1_01_10);
    ready_i[1] = 1'b1;
    step();
    clr();
    valid_i[1] = 1'b1; data_i[W +: W] = 8'h5;
    repeat (3) step();
    ready_i[1] = 1'b1;
    step();
    idle();
    step();
    chk("stable_noerr", {first_err_v_o, 64'(err_sticky_o)}, 0);
    clr();
    pulses = 0;
    valid_i[3] = 1'b1; data_i[3*W +: W] = 8'h3C;
    for (int i = 0; i < 10; i++) begin
      step();
      if (err_v_o) pulses++;
      if (i == 3) chk("to_when", 64'(err_v_o), 1);
    end
    chk("to_pulses", 64'(pulses), 1);
    chk("to_sticky", 64'(err_sticky_o), 64'h800);
    chk("to_first", {first_err_v_o, first_err_chan_o, first_err_code_o}, 5'b1_11_11);
    ready_i[3] = 1'b1;
    step();
    clr();
    valid_i[1:0] = 2'b11;
    step();
    valid_i[1:0] = 2'b00;
    step();
    chk("sim_sticky", 64'(err_sticky_o), 64'h9);
    chk("sim_first", {first_err_v_o, first_err_chan_o, first_err_code_o}, 5'b1_00_01);
    valid_i[3] = 1'b1;
    step();
    valid_i[3] = 1'b0;
    step();
    chk("later_errv", 64'(err_v_o), 1);
    chk("later_sticky", 64'(err_sticky_o), 64'h209);
    chk("later_first", {first_err_v_o, first_err_chan_o, first_err_code_o}, 5'b1_00_01);
    clr();
    chk_zero("clr2");
    chk("clr2_errv", 64'(err_v_o), 0);
    valid_i[0] = 1'b1; ready_i[0] = 1'b1;
    repeat (2) step();
    idle();
    valid_i[1] = 1'b1;
    step();
    valid_i[1] = 1'b0; valid_i[2] = 1'b1;
    step();
    chk("pre_rst", {64'(count_o[N-1:0]), 64'(err_sticky_o)}, {64'd2, 64'h8});
    #2 reset_i = 1'b1;
    #1;
    chk_zero("async_rst");
    chk("async_rst_errv", 64'(err_v_o), 0);
    idle();
    step();
    reset_i = 1'b0;
    step();
    chk("post_rst", {err_v_o, first_err_v_o, 64'(err_sticky_o)}, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
